// File: rtl/b_correct_sender.sv
// Branch-correction sender: takes resolved branches from execute, detects direction or
// target mispredicts, queues correction packets {correct_pc, hitcnt, dir, slot} and sends
// them to the front end, one packet outstanding at a time on a drive/free handshake.
// Results tagged with the squashed (old) epoch are accepted and dropped.

module b_correct_sender #(
    parameter int unsigned QDEPTH = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,

    // Resolved-branch input from execute
    input  logic             i_resolve_valid,
    output logic             o_resolve_ready,
    input  logic             i_resolve_epoch,
    input  logic             i_is_cond,
    input  logic             i_pred_taken,
    input  logic             i_actual_taken,
    input  logic [31:0]      i_pred_target,
    input  logic [31:0]      i_actual_target,
    input  logic [31:0]      i_fallthrough_pc,
    input  logic [5:0]       i_slot,

    // Correction channel to the front end
    output logic             o_drive_back,
    output logic [41:0]      o_data_back,
    input  logic             i_free_back,

    // Epoch and statistics
    output logic             o_epoch,
    output logic [CNT_W-1:0] o_mispredict_cnt
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned PKT_W = 42;

    typedef enum logic [0:0] {
        StIdle,
        StWait
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [PKT_W-1:0]   data_q, data_d;
    logic               drive_q, drive_d;
    logic               epoch_q, epoch_d;
    logic [2:0]         hitcnt_q, hitcnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_en_q;

    logic [PKT_W-1:0]   mem_q [QDEPTH];
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;

    // ------------------------------------------------------------------
    // Queue status
    // ------------------------------------------------------------------
    logic q_empty;
    logic q_full;

    assign q_empty = (wr_ptr_q == rd_ptr_q);
    // Same slot index but opposite wrap bit means the writer lapped the reader.
    assign q_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // ------------------------------------------------------------------
    // Result classification
    // ------------------------------------------------------------------
    logic             accept;
    logic             current;
    logic             mispredict;
    logic             push;
    logic             pop;
    logic [31:0]      correct_pc;
    logic [PKT_W-1:0] push_pkt;

    // ready_en_q keeps ready low while in reset and for the release edge,
    // so ready depends on registered state only.
    assign o_resolve_ready = ready_en_q & ~q_full;
    assign accept          = i_resolve_valid & o_resolve_ready;
    assign current         = accept & (i_resolve_epoch == epoch_q);

    assign mispredict = (i_is_cond & (i_pred_taken != i_actual_taken)) |
                        (i_actual_taken & (i_pred_target != i_actual_target));

    assign push       = current & mispredict;
    assign correct_pc = i_actual_taken ? i_actual_target : i_fallthrough_pc;
    // The counter field carries hits seen before this branch; the branch itself is not counted.
    assign push_pkt   = {correct_pc, hitcnt_q, i_actual_taken, i_slot};

    // ------------------------------------------------------------------
    // Epoch, hit counter and mispredict statistics: next state
    // ------------------------------------------------------------------
    always_comb begin
        epoch_d  = epoch_q;
        hitcnt_d = hitcnt_q;
        cnt_d    = cnt_q;
        if (push) begin
            epoch_d  = ~epoch_q;
            hitcnt_d = 3'd0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (current && i_is_cond && (hitcnt_q != 3'd7)) begin
            hitcnt_d = hitcnt_q + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Send FSM: next state, launch and output data
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        drive_d = 1'b0;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (!q_empty) begin
                    pop     = 1'b1;
                    drive_d = 1'b1;
                    data_d  = mem_q[rd_ptr_q[PTR_W-1:0]];
                    state_d = StWait;
                end
            end
            StWait: begin
                // A free coinciding with the launch pulse belongs to the previous packet.
                if (i_free_back && !drive_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Queue pointers: next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // FSM state and the launched packet / drive pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            drive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            drive_q <= drive_d;
        end
    end

    // Epoch, hit counter, statistics and the post-reset ready enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            epoch_q    <= 1'b0;
            hitcnt_q   <= 3'd0;
            cnt_q      <= '0;
            ready_en_q <= 1'b0;
        end else begin
            epoch_q    <= epoch_d;
            hitcnt_q   <= hitcnt_d;
            cnt_q      <= cnt_d;
            ready_en_q <= 1'b1;
        end
    end

    // Queue pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Queue storage; written only on a push, which cannot happen while full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(QDEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_pkt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_drive_back     = drive_q;
    assign o_data_back      = data_q;
    assign o_epoch          = epoch_q;
    assign o_mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_b_correct_sender.sv
// Self-checking bench for b_correct_sender: a reference model computes each expected
// correction packet when a result is driven and queues it; packets are popped and
// compared when the DUT pulses o_drive_back.

module tb_b_correct_sender;

    localparam int unsigned QDEPTH = 2;
    localparam int unsigned CNT_W  = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             i_resolve_valid = 1'b0;
    logic             o_resolve_ready;
    logic             i_resolve_epoch = 1'b0;
    logic             i_is_cond = 1'b0;
    logic             i_pred_taken = 1'b0;
    logic             i_actual_taken = 1'b0;
    logic [31:0]      i_pred_target = '0;
    logic [31:0]      i_actual_target = '0;
    logic [31:0]      i_fallthrough_pc = '0;
    logic [5:0]       i_slot = '0;
    logic             o_drive_back;
    logic [41:0]      o_data_back;
    logic             i_free_back = 1'b0;
    logic             o_epoch;
    logic [CNT_W-1:0] o_mispredict_cnt;

    b_correct_sender #(
        .QDEPTH (QDEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_resolve_valid  (i_resolve_valid),
        .o_resolve_ready  (o_resolve_ready),
        .i_resolve_epoch  (i_resolve_epoch),
        .i_is_cond        (i_is_cond),
        .i_pred_taken     (i_pred_taken),
        .i_actual_taken   (i_actual_taken),
        .i_pred_target    (i_pred_target),
        .i_actual_target  (i_actual_target),
        .i_fallthrough_pc (i_fallthrough_pc),
        .i_slot           (i_slot),
        .o_drive_back     (o_drive_back),
        .o_data_back      (o_data_back),
        .i_free_back      (i_free_back),
        .o_epoch          (o_epoch),
        .o_mispredict_cnt (o_mispredict_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int drive_cnt = 0;

    logic [41:0]      sb_q [$];
    logic [41:0]      last_pkt = '0;
    logic             model_epoch = 1'b0;
    logic [2:0]       model_hit = 3'd0;
    logic [CNT_W-1:0] model_cnt = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every launch must match the oldest expected packet.
    always @(negedge clk) begin
        if (rst && o_drive_back) begin
            drive_cnt++;
            check_eq("drive_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                last_pkt = sb_q.pop_front();
                check_eq("pkt_data", 64'(o_data_back), 64'(last_pkt));
            end
        end
    end

    // Drive one result for one cycle (entered and left on a negedge) and update the model.
    task automatic resolve(input logic cond, input logic pt, input logic at,
                           input logic [31:0] ptgt, input logic [31:0] atgt,
                           input logic [31:0] fall, input logic [5:0] slot,
                           input logic stale);
        int          n;
        logic        mis;
        logic [31:0] cpc;
        n = 0;
        while (!o_resolve_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_before_resolve", 64'(o_resolve_ready), 64'd1);
        i_resolve_valid  = 1'b1;
        i_resolve_epoch  = stale ? ~model_epoch : model_epoch;
        i_is_cond        = cond;
        i_pred_taken     = pt;
        i_actual_taken   = at;
        i_pred_target    = ptgt;
        i_actual_target  = atgt;
        i_fallthrough_pc = fall;
        i_slot           = slot;
        if (!stale) begin
            mis = (cond && (pt != at)) || (at && (ptgt != atgt));
            cpc = at ? atgt : fall;
            if (mis) begin
                sb_q.push_back({cpc, model_hit, at, slot});
                model_hit   = 3'd0;
                model_epoch = ~model_epoch;
                if (model_cnt != {CNT_W{1'b1}}) model_cnt = model_cnt + 1'b1;
            end else if (cond && model_hit != 3'd7) begin
                model_hit = model_hit + 3'd1;
            end
        end
        @(negedge clk);
        i_resolve_valid = 1'b0;
    endtask

    task automatic free_pulse();
        i_free_back = 1'b1;
        @(negedge clk);
        i_free_back = 1'b0;
    endtask

    // Bounded wait for a launch pulse.
    task automatic wait_drive(input string tag);
        int   n;
        logic seen;
        n    = 0;
        seen = o_drive_back;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = o_drive_back;
        end
        check_eq(tag, 64'(seen), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;

        // Reset state
        #1;
        check_eq("rst_drive", 64'(o_drive_back), 64'd0);
        check_eq("rst_data", 64'(o_data_back), 64'd0);
        check_eq("rst_epoch", 64'(o_epoch), 64'd0);
        check_eq("rst_cnt", 64'(o_mispredict_cnt), 64'd0);
        check_eq("rst_ready", 64'(o_resolve_ready), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", 64'(o_resolve_ready), 64'd1);

        // 1: simple not-taken mispredict
        resolve(1'b1, 1'b1, 1'b0, 32'h500, 32'h600, 32'h100, 6'd3, 1'b0);
        check_eq("t1_epoch", 64'(o_epoch), 64'd1);
        check_eq("t1_cnt", 64'(o_mispredict_cnt), 64'd1);
        check_eq("t1_no_drive_yet", 64'(o_drive_back), 64'd0);
        @(negedge clk);
        #1;
        check_eq("t1_drive", 64'(o_drive_back), 64'd1);
        check_eq("t1_data", 64'(o_data_back), 64'({32'h100, 3'd0, 1'b0, 6'd3}));
        @(negedge clk);
        check_eq("t1_drive_one_cycle", 64'(o_drive_back), 64'd0);
        free_pulse();
        repeat (2) @(negedge clk);

        // 2: ten correct cond branches saturate the hit counter
        for (int i = 0; i < 10; i++) begin
            resolve(1'b1, i[0], i[0], 32'h3000 + 32'(i), 32'h3000 + 32'(i),
                    32'h4000, 6'(i), 1'b0);
        end
        resolve(1'b1, 1'b0, 1'b1, 32'h0, 32'h2000, 32'h104, 6'd9, 1'b0);
        wait_drive("t2_drive");
        check_eq("t2_counter", 64'(o_data_back[9:7]), 64'd7);
        check_eq("t2_pc", 64'(o_data_back[41:10]), 64'h2000);
        check_eq("t2_dir", 64'(o_data_back[6]), 64'd1);
        @(negedge clk);
        free_pulse();
        repeat (2) @(negedge clk);

        // 3: three back-to-back mispredicts with free withheld
        base = drive_cnt;
        resolve(1'b1, 1'b0, 1'b1, 32'h10, 32'h20, 32'h30, 6'd10, 1'b0);
        resolve(1'b1, 1'b1, 1'b0, 32'h40, 32'h50, 32'h60, 6'd11, 1'b0);
        resolve(1'b0, 1'b1, 1'b1, 32'h70, 32'h80, 32'h90, 6'd12, 1'b0);
        #1;
        check_eq("t3_ready_full", 64'(o_resolve_ready), 64'd0);
        check_eq("t3_first_only", 64'(drive_cnt), 64'(base + 1));
        check_eq("t3_epoch", 64'(o_epoch), 64'(model_epoch));
        repeat (3) @(negedge clk);
        #1;
        check_eq("t3_hold_data", 64'(o_data_back), 64'(last_pkt));
        check_eq("t3_no_more_drive", 64'(drive_cnt), 64'(base + 1));
        check_eq("t3_still_full", 64'(o_resolve_ready), 64'd0);
        free_pulse();
        check_eq("t3_p2_not_early", 64'(o_drive_back), 64'd0);
        @(negedge clk);
        check_eq("t3_p2_drive", 64'(o_drive_back), 64'd1);
        // Free in the launch cycle of packet 2 must be ignored.
        free_pulse();
        repeat (3) @(negedge clk);
        #1;
        check_eq("t3_free_same_cycle_ignored", 64'(drive_cnt), 64'(base + 2));
        check_eq("t3_ready_after_pop", 64'(o_resolve_ready), 64'd1);
        free_pulse();
        check_eq("t3_p3_not_early", 64'(o_drive_back), 64'd0);
        @(negedge clk);
        check_eq("t3_p3_drive", 64'(o_drive_back), 64'd1);
        @(negedge clk);
        free_pulse();
        repeat (2) @(negedge clk);

        // 4: stale-epoch mispredict has no effect
        base = drive_cnt;
        resolve(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h500, 6'd20, 1'b1);
        resolve(1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 32'h500, 6'd21, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        check_eq("t4_no_drive", 64'(drive_cnt), 64'(base));
        check_eq("t4_cnt", 64'(o_mispredict_cnt), 64'(model_cnt));
        check_eq("t4_epoch", 64'(o_epoch), 64'(model_epoch));
        check_eq("t4_ready", 64'(o_resolve_ready), 64'd1);

        // 5: unconditional jump target mispredict, then a correct jump
        resolve(1'b0, 1'b1, 1'b1, 32'h40, 32'h80, 32'h1234, 6'd5, 1'b0);
        wait_drive("t5_drive");
        check_eq("t5_pc", 64'(o_data_back[41:10]), 64'h80);
        check_eq("t5_dir", 64'(o_data_back[6]), 64'd1);
        @(negedge clk);
        free_pulse();
        @(negedge clk);
        base = drive_cnt;
        resolve(1'b0, 1'b1, 1'b1, 32'h80, 32'h80, 32'h1234, 6'd6, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("t5_no_pkt", 64'(drive_cnt), 64'(base));
        resolve(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h200, 6'd7, 1'b0);
        resolve(1'b1, 1'b0, 1'b1, 32'h0, 32'h900, 32'h204, 6'd8, 1'b0);
        wait_drive("t5_drive2");
        check_eq("t5_counter_one", 64'(o_data_back[9:7]), 64'd1);
        @(negedge clk);
        free_pulse();
        repeat (2) @(negedge clk);

        // 6: reset while waiting with one packet queued
        resolve(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h700, 6'd30, 1'b0);
        resolve(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h800, 6'd31, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        model_epoch = 1'b0;
        model_hit   = 3'd0;
        model_cnt   = '0;
        #1;
        check_eq("t6_rst_drive", 64'(o_drive_back), 64'd0);
        check_eq("t6_rst_data", 64'(o_data_back), 64'd0);
        check_eq("t6_rst_epoch", 64'(o_epoch), 64'd0);
        check_eq("t6_rst_cnt", 64'(o_mispredict_cnt), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        base = drive_cnt;
        repeat (6) @(negedge clk);
        check_eq("t6_no_drive_after_rst", 64'(drive_cnt), 64'(base));
        check_eq("t6_ready", 64'(o_resolve_ready), 64'd1);
        resolve(1'b1, 1'b0, 1'b1, 32'h0, 32'hA00, 32'h0, 6'd1, 1'b0);
        check_eq("t6_epoch", 64'(o_epoch), 64'd1);
        @(negedge clk);
        check_eq("t6_new_drive", 64'(o_drive_back), 64'd1);
        @(negedge clk);
        free_pulse();
        repeat (2) @(negedge clk);

        check_eq("final_cnt", 64'(o_mispredict_cnt), 64'(model_cnt));
        check_eq("final_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
